// File: rtl/sys_array_pkg.sv
// Shared sizes, data types and controller states for the systolic array sequencer.
package sys_array_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int ARRAY_MAX_W = 10;
  localparam int ARRAY_MAX_L = 10;
  localparam int LW          = $clog2(ARRAY_MAX_L);
  localparam int PIPE_DEPTH  = ARRAY_MAX_L + ARRAY_MAX_W + 2;

  typedef logic [DATA_WIDTH-1:0]                         operand_t;
  typedef logic [2*DATA_WIDTH-1:0]                       result_t;
  typedef logic [ARRAY_MAX_L*DATA_WIDTH-1:0]             in_vec_t;
  typedef logic [ARRAY_MAX_W*2*DATA_WIDTH-1:0]           out_vec_t;
  typedef logic [ARRAY_MAX_W*ARRAY_MAX_L*DATA_WIDTH-1:0] w_tile_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_STREAM,
    ST_DRAIN
  } ctrl_state_e;
endpackage

// File: rtl/sys_array_skew.sv
// Triangular delay line: lane k is delayed k stages (or LANES-1-k when REVERSE),
// always followed by an output register that only loads while load_en is high.
module sys_array_skew
  import sys_array_pkg::*;
#(
  parameter int LANES   = 10,
  parameter int WIDTH   = 8,
  parameter bit REVERSE = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES*WIDTH-1:0] out_data
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int DEPTH = REVERSE ? (LANES - 1 - k) : k;

    logic [WIDTH-1:0] stage_q [DEPTH+1];
    logic [WIDTH-1:0] stage_d [DEPTH+1];

    always_comb begin
      stage_d    = stage_q;
      stage_d[0] = in_data[k*WIDTH +: WIDTH];
      for (int n = 1; n <= DEPTH; n++) begin
        stage_d[n] = stage_q[n-1];
      end
      if (!load_en) begin
        stage_d[DEPTH] = stage_q[DEPTH];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int n = 0; n <= DEPTH; n++) begin
          stage_q[n] <= '0;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign out_data[k*WIDTH +: WIDTH] = stage_q[DEPTH];
  end

endmodule

// File: rtl/sys_array_ctrl.sv
// Job sequencer for the weight-stationary array: loads one weight tile, streams
// skewed input vectors, tracks result validity and emits de-skewed result beats.
module sys_array_ctrl
  import sys_array_pkg::*;
(
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [LW-1:0]                               cfg_l,
  input  logic                                        start,
  output logic                                        busy,
  output logic                                        done,
  input  logic                                        w_valid,
  output logic                                        w_ready,
  input  logic [ARRAY_MAX_W*ARRAY_MAX_L*DATA_WIDTH-1:0] w_data,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic                                        in_last,
  input  logic [ARRAY_MAX_L*DATA_WIDTH-1:0]           in_data,
  output logic                                        arr_weights_load,
  output logic [LW-1:0]                               arr_array_w_l,
  output logic [ARRAY_MAX_W*ARRAY_MAX_L*DATA_WIDTH-1:0] arr_weight_data,
  output logic [ARRAY_MAX_L*DATA_WIDTH-1:0]           arr_input_data,
  input  logic [ARRAY_MAX_W*2*DATA_WIDTH-1:0]         arr_output_data,
  output logic                                        out_valid,
  output logic                                        out_last,
  output logic [ARRAY_MAX_W*2*DATA_WIDTH-1:0]         out_data
);

  localparam int TW = $clog2(PIPE_DEPTH);

  ctrl_state_e           state_q, state_d;
  logic [LW-1:0]         cfg_l_q, cfg_l_d;
  w_tile_t               weight_q, weight_d;
  logic                  wload_q, wload_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  w_ready_q, w_ready_d;
  logic                  in_ready_q, in_ready_d;
  logic [PIPE_DEPTH-1:0] vpipe_q, vpipe_d;
  logic [PIPE_DEPTH-1:0] lpipe_q, lpipe_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  accept;
  logic [TW-1:0]         tap;
  in_vec_t               skew_in;

  assign accept = in_valid && in_ready_q;
  // pipe bit k is visible k+1 cycles after accept; one more register reaches LAT
  assign tap    = TW'(cfg_l_q) + TW'(ARRAY_MAX_W);

  always_comb begin
    skew_in = '0;
    for (int j = 0; j < ARRAY_MAX_L; j++) begin
      if (accept && (j <= int'(cfg_l_q))) begin
        skew_in[j*DATA_WIDTH +: DATA_WIDTH] = in_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_l_d     = cfg_l_q;
    weight_d    = weight_q;
    wload_d     = 1'b0;
    done_d      = 1'b0;
    vpipe_d     = {vpipe_q[PIPE_DEPTH-2:0], accept};
    lpipe_d     = {lpipe_q[PIPE_DEPTH-2:0], accept && in_last};
    out_valid_d = vpipe_q[tap];
    out_last_d  = lpipe_q[tap];
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_l_d = cfg_l;
          state_d = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (w_valid && w_ready_q) begin
          weight_d = w_data;
          wload_d  = 1'b1;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (accept && in_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_last_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d     = (state_d != ST_IDLE);
    w_ready_d  = (state_d == ST_LOAD_W);
    in_ready_d = (state_d == ST_STREAM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cfg_l_q     <= '0;
      weight_q    <= '0;
      wload_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_ready_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      vpipe_q     <= '0;
      lpipe_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_l_q     <= cfg_l_d;
      weight_q    <= weight_d;
      wload_q     <= wload_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      w_ready_q   <= w_ready_d;
      in_ready_q  <= in_ready_d;
      vpipe_q     <= vpipe_d;
      lpipe_q     <= lpipe_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  sys_array_skew #(
    .LANES  (ARRAY_MAX_L),
    .WIDTH  (DATA_WIDTH),
    .REVERSE(1'b0)
  ) u_in_skew (
    .clk     (clk),
    .reset   (reset),
    .load_en (1'b1),
    .in_data (skew_in),
    .out_data(arr_input_data)
  );

  // the final de-skew register loads only on a beat so out_data holds between beats
  sys_array_skew #(
    .LANES  (ARRAY_MAX_W),
    .WIDTH  (2*DATA_WIDTH),
    .REVERSE(1'b1)
  ) u_out_deskew (
    .clk     (clk),
    .reset   (reset),
    .load_en (out_valid_d),
    .in_data (arr_output_data),
    .out_data(out_data)
  );

  assign busy             = busy_q;
  assign done             = done_q;
  assign w_ready          = w_ready_q;
  assign in_ready         = in_ready_q;
  assign arr_weights_load = wload_q;
  assign arr_array_w_l    = cfg_l_q;
  assign arr_weight_data  = weight_q;
  assign out_valid        = out_valid_q;
  assign out_last         = out_last_q;

endmodule
